// File: rtl/rvfi_tohost_monitor_pkg.sv
// rvfi_monitor_pkg: commit-port record, monitor states and word/doubleword store decode
package rvfi_monitor_pkg;
   localparam int TOHOST_UPPER_OFFSET = 4;
   typedef enum logic [1:0] {IDLE, RUN, DONE, TIMEOUT} mon_state_e;
   typedef struct packed {
      logic        valid;
      logic        trap;
      logic [31:0] insn;
      logic [63:0] pc_rdata;
      logic [63:0] mem_addr;
      logic [7:0]  mem_wmask;
      logic [63:0] mem_wdata;
   } rvfi_instr_t;
   function automatic logic is_store_wd(logic [31:0] insn, int xlen);
      logic w_rv64;
      w_rv64 = (xlen == 64);
      is_store_wd = (insn[6:0] == 7'b0100011 && (insn[14:12] == 3'b010 || (w_rv64 && insn[14:12] == 3'b011)))
                 || (insn[1:0] == 2'b00 && (insn[15:13] == 3'b110 || (w_rv64 && insn[15:13] == 3'b111)));
   endfunction
endpackage

// File: rtl/rvfi_tohost_monitor_if.sv
// rvfi_tohost_monitor_if: bundle of RVFI commit ports observed by the monitor
interface rvfi_tohost_monitor_if #(parameter int NR = 2) ();
   rvfi_monitor_pkg::rvfi_instr_t [NR-1:0] rvfi;
   modport master (output rvfi);
   modport slave  (input  rvfi);
endinterface

// File: rtl/rvfi_tohost_monitor_port.sv
// rvfi_tohost_port: per-port tohost capture with same-cycle bypass,
// trap cancellation and terminate flag
module rvfi_tohost_port import rvfi_monitor_pkg::*; #(
   parameter int XLEN = 64
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            active_i,
   input  logic [XLEN-1:0] tohost_addr_i,
   input  logic            valid_i,
   input  logic            trap_i,
   input  logic [31:0]     insn_i,
   input  logic [XLEN-1:0] addr_i,
   input  logic [7:0]      wmask_i,
   input  logic [XLEN-1:0] wdata_i,
   output logic            term_o,
   output logic            upper_hit_o,
   output logic [XLEN-1:0] data_o
);
   logic            r_pend;
   logic [XLEN-1:0] r_pdata;
   logic            w_wr, w_cap, w_consume;
   assign w_wr        = active_i && tohost_addr_i != '0 && wmask_i != '0 && wdata_i != '0;
   assign w_cap       = w_wr && addr_i == tohost_addr_i;
   assign upper_hit_o = w_wr && addr_i == tohost_addr_i + XLEN'(TOHOST_UPPER_OFFSET);
   assign w_consume   = active_i && valid_i && is_store_wd(insn_i, XLEN) && (r_pend || w_cap);
   assign data_o      = w_cap ? wdata_i : r_pdata;
   assign term_o      = w_consume && data_o[0];
   // a consumed or trapped capture must not terminate a later store
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         r_pend  <= 1'b0;
         r_pdata <= '0;
      end else begin
         if (w_cap) r_pdata <= wdata_i;
         if (active_i && trap_i && !valid_i) r_pend <= 1'b0;
         else if (w_consume) r_pend <= 1'b0;
         else if (w_cap) r_pend <= 1'b1;
      end
endmodule

// File: rtl/rvfi_tohost_monitor.sv
// rvfi_tohost_monitor: end-of-test detector on RVFI commit ports with port priority,
// sticky DONE/TIMEOUT state machine and saturating cycle watchdog
module rvfi_tohost_monitor import rvfi_monitor_pkg::*; #(
   parameter  int NR_COMMIT_PORTS = 2,
   parameter  int XLEN            = 64,
   parameter  int CNT_W           = 32,
   localparam int PW              = NR_COMMIT_PORTS > 1 ? $clog2(NR_COMMIT_PORTS) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 enable_i,
   input  logic [XLEN-1:0]      tohost_addr_i,
   input  logic [CNT_W-1:0]     timeout_i,
   rvfi_tohost_monitor_if.slave rvfi_i,
   output logic                 done_o,
   output logic                 pass_o,
   output logic [63:0]          exit_code_o,
   output logic [63:0]          done_pc_o,
   output logic [PW-1:0]        done_port_o,
   output logic                 timeout_o,
   output logic [CNT_W-1:0]     cycles_o
);
   mon_state_e                 r_state, w_next;
   logic                       w_active, w_any, w_timeout;
   logic [NR_COMMIT_PORTS-1:0] w_term, w_upper_hit;
   logic [XLEN-1:0]            w_data [NR_COMMIT_PORTS];
   logic [XLEN-1:0]            w_sel_data;
   logic [63:0]                w_sel_pc, w_code;
   logic [PW-1:0]              w_sel_port;
   logic [31:0]                r_upper, w_upper_d;
   assign w_active = r_state == RUN && enable_i;
   for (genvar i = 0; i < NR_COMMIT_PORTS; i++) begin : g_port
      rvfi_tohost_port #(.XLEN(XLEN)) u_port (
         .clk_i        (clk_i),
         .rst_ni       (rst_ni),
         .active_i     (w_active),
         .tohost_addr_i(tohost_addr_i),
         .valid_i      (rvfi_i.rvfi[i].valid),
         .trap_i       (rvfi_i.rvfi[i].trap),
         .insn_i       (rvfi_i.rvfi[i].insn),
         .addr_i       (rvfi_i.rvfi[i].mem_addr[XLEN-1:0]),
         .wmask_i      (rvfi_i.rvfi[i].mem_wmask),
         .wdata_i      (rvfi_i.rvfi[i].mem_wdata[XLEN-1:0]),
         .term_o       (w_term[i]),
         .upper_hit_o  (w_upper_hit[i]),
         .data_o       (w_data[i])
      );
   end
   // descending scan so the lowest-indexed port wins
   always_comb begin
      w_any      = 1'b0;
      w_sel_port = '0;
      w_sel_data = '0;
      w_sel_pc   = '0;
      w_upper_d  = r_upper;
      for (int i = NR_COMMIT_PORTS - 1; i >= 0; i--) begin
         if (w_upper_hit[i]) w_upper_d = rvfi_i.rvfi[i].mem_wdata[31:0];
         if (w_term[i]) begin
            w_any      = 1'b1;
            w_sel_port = PW'(i);
            w_sel_data = w_data[i];
            w_sel_pc   = 64'($signed(rvfi_i.rvfi[i].pc_rdata[XLEN-1:0]));
         end
      end
   end
   assign w_code    = (XLEN == 32) ? {r_upper, w_sel_data[31:0]} : 64'(w_sel_data);
   assign w_timeout = timeout_i != '0 && cycles_o == timeout_i - CNT_W'(1);
   always_comb begin
      w_next = r_state;
      if (r_state == IDLE && enable_i) w_next = RUN;
      else if (r_state == RUN) w_next = !enable_i ? IDLE : w_any ? DONE : w_timeout ? TIMEOUT : RUN;
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         r_state     <= IDLE;
         r_upper     <= '0;
         done_o      <= 1'b0;
         pass_o      <= 1'b0;
         exit_code_o <= '0;
         done_pc_o   <= '0;
         done_port_o <= '0;
         timeout_o   <= 1'b0;
         cycles_o    <= '0;
      end else begin
         r_state <= w_next;
         if (w_active) begin
            if (!(&cycles_o)) cycles_o <= cycles_o + CNT_W'(1);
            if (XLEN == 32) r_upper <= w_upper_d;
            if (w_any) begin
               done_o      <= 1'b1;
               pass_o      <= w_code == 64'h1;
               exit_code_o <= w_code;
               done_pc_o   <= w_sel_pc;
               done_port_o <= w_sel_port;
            end else if (w_timeout) timeout_o <= 1'b1;
         end
      end
endmodule

// File: tb/tb_rvfi_tohost_monitor.sv
// tb_rvfi_tohost_monitor: RV64 and RV32 monitors share one RVFI bus; a behavioural
// model pushes expected terminations into queues that a negedge monitor pops
module tb_rvfi_tohost_monitor;
   import rvfi_monitor_pkg::*;
   localparam int NP = 2;
   localparam int CW = 32;
   localparam logic [31:0] SW = 32'h0000_2023, SD = 32'h0000_3023, CSW = 32'h0000_C000;
   localparam logic [31:0] CSD = 32'h0000_E000, ADD = 32'h0000_0033, SB = 32'h0000_0023;
   localparam logic [31:0] INS [6] = '{SW, SD, CSW, CSD, ADD, SB};
   localparam logic [63:0] TA = 64'h8000_1000;
   typedef struct { logic [63:0] code; logic [63:0] pc; int port; } exp_t;
   logic clk = 1'b0, rst_n = 1'b1, en = 1'b0;
   logic [63:0] ta = '0;
   logic [CW-1:0] to_lim = '0;
   logic d_done [2], d_pass [2], d_to [2];
   logic [63:0] d_code [2], d_pc [2];
   logic [0:0] d_port [2];
   logic [CW-1:0] d_cyc [2];
   bit m_run [2], m_done [2], m_to [2], prev_done [2];
   bit m_pend [2][NP];
   logic [63:0] m_pdata [2][NP];
   logic [31:0] m_upper [2];
   logic [CW-1:0] m_cyc [2];
   exp_t q64 [$], q32 [$];
   int n_chk = 0, n_fail = 0;

   rvfi_tohost_monitor_if #(.NR(NP)) bus ();
   always #5 clk = ~clk;

   rvfi_tohost_monitor #(.NR_COMMIT_PORTS(NP), .XLEN(64), .CNT_W(CW)) u64 (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .tohost_addr_i(ta), .timeout_i(to_lim),
      .rvfi_i(bus), .done_o(d_done[0]), .pass_o(d_pass[0]), .exit_code_o(d_code[0]),
      .done_pc_o(d_pc[0]), .done_port_o(d_port[0]), .timeout_o(d_to[0]), .cycles_o(d_cyc[0]));
   rvfi_tohost_monitor #(.NR_COMMIT_PORTS(NP), .XLEN(32), .CNT_W(CW)) u32 (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .tohost_addr_i(ta[31:0]), .timeout_i(to_lim),
      .rvfi_i(bus), .done_o(d_done[1]), .pass_o(d_pass[1]), .exit_code_o(d_code[1]),
      .done_pc_o(d_pc[1]), .done_port_o(d_port[1]), .timeout_o(d_to[1]), .cycles_o(d_cyc[1]));

   task automatic check(string nm, int d, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s rv%0d: got 0x%0h expected 0x%0h", nm, d ? 32 : 64, act, exp);
      end
   endtask

   function automatic bit store_ok(logic [31:0] insn, int xl);
      if (insn[1:0] == 2'b11)
         return insn[6:2] == 5'b01000 && (insn[14:12] == 3'd2 || (xl == 64 && insn[14:12] == 3'd3));
      return insn[1:0] == 2'b00 && (insn[15:13] == 3'd6 || (xl == 64 && insn[15:13] == 3'd7));
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_run[d] = 0; m_done[d] = 0; m_to[d] = 0; m_upper[d] = '0; m_cyc[d] = '0;
         for (int p = 0; p < NP; p++) begin m_pend[d][p] = 0; m_pdata[d][p] = '0; end
      end
      q64.delete(); q32.delete();
   endtask

   task automatic model_step(int d);
      int xl, hp;
      logic [63:0] msk, tam, a, w, v, hd, hpc;
      logic [31:0] up_n;
      bit hit, up_set, wr, cap, use_w, tmo;
      rvfi_instr_t r;
      exp_t e;
      if (m_done[d] || m_to[d]) return;
      if (!en) begin m_run[d] = 0; return; end
      if (!m_run[d]) begin m_run[d] = 1; return; end
      xl = d ? 32 : 64;
      msk = d ? 64'hFFFF_FFFF : '1;
      tam = ta & msk;
      hit = 0; up_set = 0; up_n = m_upper[d]; hp = 0; hd = '0; hpc = '0;
      for (int p = 0; p < NP; p++) begin
         r = bus.rvfi[p];
         a = r.mem_addr & msk;
         w = r.mem_wdata & msk;
         wr = tam != 0 && r.mem_wmask != 0 && w != 0;
         cap = wr && a == tam;
         use_w = r.valid && store_ok(r.insn, xl) && (m_pend[d][p] || cap);
         v = cap ? w : m_pdata[d][p];
         if (use_w && v[0] && !hit) begin
            hit = 1; hp = p; hd = v;
            hpc = d ? {{32{r.pc_rdata[31]}}, r.pc_rdata[31:0]} : r.pc_rdata;
         end
         if (d == 1 && wr && a == ((tam + 4) & msk) && !up_set) begin up_n = w[31:0]; up_set = 1; end
         if (cap) m_pdata[d][p] = w;
         if (r.trap && !r.valid) m_pend[d][p] = 0;
         else if (use_w) m_pend[d][p] = 0;
         else if (cap) m_pend[d][p] = 1;
      end
      tmo = to_lim != 0 && m_cyc[d] == to_lim - 1;
      if (m_cyc[d] != '1) m_cyc[d] = m_cyc[d] + 1;
      if (hit) begin
         e.code = d ? {m_upper[d], hd[31:0]} : hd;
         e.pc = hpc;
         e.port = hp;
         m_done[d] = 1;
         if (d) q32.push_back(e); else q64.push_back(e);
      end else if (tmo) m_to[d] = 1;
      m_upper[d] = up_n;
   endtask

   task automatic idle_bus();
      for (int p = 0; p < NP; p++) bus.rvfi[p] = '0;
   endtask

   task automatic set_port(int p, bit v, bit tr, logic [31:0] insn, logic [63:0] addr, logic [63:0] wd);
      bus.rvfi[p].valid = v;
      bus.rvfi[p].trap = tr;
      bus.rvfi[p].insn = insn;
      bus.rvfi[p].pc_rdata = 64'h8000_0000 | 64'($urandom_range(0, 4095) << 2);
      bus.rvfi[p].mem_addr = addr;
      bus.rvfi[p].mem_wmask = 8'hFF;
      bus.rvfi[p].mem_wdata = wd;
   endtask

   task automatic rand_port(int p);
      logic [63:0] adr, wd;
      case ($urandom_range(0, 3))
         0: adr = ta;
         1: adr = ta + 4;
         2: adr = ta | 64'h1_0000_0000;
         default: adr = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 6))
         0: wd = '0;
         1: wd = 64'h1;
         2: wd = 64'h3;
         3: wd = 64'h2_0000_0000;
         4: wd = 64'hFFFF_FFFF_0000_0001;
         default: wd = {$urandom, $urandom};
      endcase
      bus.rvfi[p].valid = 1'($urandom_range(0, 1));
      bus.rvfi[p].trap = $urandom_range(0, 5) == 0;
      bus.rvfi[p].insn = INS[$urandom_range(0, 5)];
      bus.rvfi[p].pc_rdata = {$urandom, $urandom};
      bus.rvfi[p].mem_addr = adr;
      bus.rvfi[p].mem_wmask = $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom);
      bus.rvfi[p].mem_wdata = wd;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) begin model_step(0); model_step(1); end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; en = 1'b0; to_lim = '0;
      idle_bus();
      model_reset();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic check_zero(string nm);
      for (int d = 0; d < 2; d++) begin
         check({nm, "_done"}, d, d_done[d], 0);
         check({nm, "_pass"}, d, d_pass[d], 0);
         check({nm, "_code"}, d, d_code[d], 0);
         check({nm, "_pc"}, d, d_pc[d], 0);
         check({nm, "_port"}, d, d_port[d], 0);
         check({nm, "_timeout"}, d, d_to[d], 0);
         check({nm, "_cycles"}, d, d_cyc[d], 0);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         check("done", d, d_done[d], m_done[d]);
         check("timeout", d, d_to[d], m_to[d]);
         check("cycles", d, d_cyc[d], m_cyc[d]);
         if (d_done[d] && !prev_done[d]) begin
            n_chk++;
            if ((d ? q32.size() : q64.size()) == 0) begin
               n_fail++;
               $display("FAIL record rv%0d: done raised, got no expected termination", d ? 32 : 64);
            end else begin
               e = d ? q32.pop_front() : q64.pop_front();
               check("exit_code", d, d_code[d], e.code);
               check("done_pc", d, d_pc[d], e.pc);
               check("done_port", d, d_port[d], 64'(e.port));
               check("pass", d, d_pass[d], e.code == 64'h1);
            end
         end
         prev_done[d] = d_done[d];
      end
   end

   initial begin
      idle_bus();
      model_reset();
      #1;
      do_reset();
      check_zero("reset");
      // same-cycle bypass on port0 (SD is not a word/doubleword store on RV32)
      ta = TA; en = 1'b1; tick();
      set_port(0, 1, 0, SD, TA, 64'h1); tick(); idle_bus();
      check("t1_done", 0, d_done[0], 1);
      check("t1_pass", 0, d_pass[0], 1);
      check("t1_code", 0, d_code[0], 64'h1);
      check("t1_port", 0, d_port[0], 0);
      check("t1_nodone", 1, d_done[1], 0);
      // earlier capture on port1, later C.SD consumes it
      do_reset(); ta = TA; en = 1'b1; tick();
      set_port(1, 0, 0, ADD, TA, 64'h7); tick(); idle_bus(); tick(); tick();
      check("t2_early", 0, d_done[0], 0);
      set_port(1, 1, 0, CSD, 64'h100, 64'h0); tick(); idle_bus();
      check("t2_done", 0, d_done[0], 1);
      check("t2_code", 0, d_code[0], 64'h7);
      check("t2_pass", 0, d_pass[0], 0);
      check("t2_port", 0, d_port[0], 1);
      // simultaneous terminations
      do_reset(); ta = TA; en = 1'b1; tick();
      set_port(0, 1, 0, SW, TA, 64'h1); set_port(1, 1, 0, SW, TA, 64'h3); tick(); idle_bus();
      for (int d = 0; d < 2; d++) begin
         check("t3_port", d, d_port[d], 0);
         check("t3_code", d, d_code[d], 64'h1);
      end
      // trap cancels the capture, watchdog fires
      do_reset(); ta = TA; to_lim = 50; en = 1'b1; tick();
      set_port(0, 0, 0, ADD, TA, 64'h1); tick();
      set_port(0, 0, 1, ADD, 64'h40, 64'h0); tick();
      set_port(0, 1, 0, SW, 64'h40, 64'h0); tick(); idle_bus();
      repeat (50) tick();
      for (int d = 0; d < 2; d++) begin
         check("t4_timeout", d, d_to[d], 1);
         check("t4_cycles", d, d_cyc[d], 50);
         check("t4_nodone", d, d_done[d], 0);
      end
      // RV32 upper word
      do_reset(); ta = TA; en = 1'b1; tick();
      set_port(0, 1, 0, SW, TA + 4, 64'hDEAD); tick();
      set_port(0, 1, 0, SW, TA, 64'h1); tick(); idle_bus();
      check("t5_done", 1, d_done[1], 1);
      check("t5_code", 1, d_code[1], 64'h0000_DEAD_0000_0001);
      check("t5_pass", 1, d_pass[1], 0);
      // asynchronous reset while DONE
      rst_n = 1'b0; model_reset(); #2;
      check_zero("t6_async");
      tick(); tick(); rst_n = 1'b1;
      en = 1'b1; tick();
      repeat (5) tick();
      check("t6_run", 0, d_cyc[0], 5);
      en = 1'b0;
      repeat (10) tick();
      check("t6_hold", 0, d_cyc[0], 5);
      en = 1'b1; tick(); tick();
      check("t6_resume", 0, d_cyc[0], 6);
      do_reset(); ta = '0; en = 1'b1; tick();
      repeat (5) begin set_port(0, 1, 0, SW, 64'h0, 64'h1); set_port(1, 1, 0, SD, 64'h0, 64'h1); tick(); end
      idle_bus(); tick();
      for (int d = 0; d < 2; d++) check("t6_zero_addr", d, d_done[d], 0);
      // randomized episodes
      for (int ep = 0; ep < 40; ep++) begin
         do_reset();
         ta = $urandom_range(0, 9) == 0 ? 64'h0 : (64'h8000_0000 | (64'($urandom_range(0, 255)) << 3));
         to_lim = $urandom_range(0, 2) == 0 ? '0 : CW'($urandom_range(5, 40));
         en = 1'b1;
         for (int c = 0; c < 40; c++) begin
            if ($urandom_range(0, 9) == 0) en = ~en;
            for (int p = 0; p < NP; p++) rand_port(p);
            tick();
         end
      end
      idle_bus();
      @(negedge clk); #1;
      check("q64_drained", 0, 64'(q64.size()), 0);
      check("q32_drained", 1, 64'(q32.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/rvfi_tohost_monitor.md
Name: rvfi_tohost_monitor

Overview:
Synthesizable, parametrised end-of-test monitor on the RVFI commit ports. It detects the "test result" write into tohost on any of NR_COMMIT_PORTS ports and reports exit status and exit code as registered outputs, with a cycle watchdog. It sits beside the RVFI tracer in the testbench and in FPGA/emulation builds, where DPI termination is unavailable. Compared with the tracer's termination logic it adds:
- the upper tohost word on RV32;
- same-cycle bypass;
- trap cancellation;
- deterministic port priority;
- a sticky state machine.

Parameters:
- NR_COMMIT_PORTS, 2, number of rvfi_i ports monitored.
- XLEN, riscv::XLEN, 32 or 64; selects store decode and RV32 upper-word handling.
- CNT_W, 32, width of the cycle counter and timeout comparator.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- enable_i  in  1  monitor runs while high; while low the counter holds and no detection occurs.
- tohost_addr_i  in  XLEN  tohost address, XLEN-aligned; value 0 disables detection.
- timeout_i  in  CNT_W  watchdog limit in cycles; value 0 disables the watchdog.
- rvfi_i  in  NR_COMMIT_PORTS x rvfi_pkg::rvfi_instr_t  commit ports.
- done_o  out  1  sticky; test terminated by a tohost write.
- pass_o  out  1  valid with done_o; exit_code_o == 1.
- exit_code_o  out  64  tohost value; on RV32 {upper word, lower word}.
- done_pc_o  out  64  sign-extended PC of the terminating store.
- done_port_o  out  $clog2(NR_COMMIT_PORTS) (minimum 1)  port that terminated.
- timeout_o  out  1  sticky; watchdog expired.
- cycles_o  out  CNT_W  cycles spent in RUN, saturating.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; all per-port pending captures cleared; upper-word register cleared.
- FSM states IDLE, RUN, DONE, TIMEOUT.
  - IDLE -> RUN when enable_i = 1.
  - RUN -> IDLE when enable_i = 0. Counter and pending captures are held.
  - RUN -> DONE on a terminate event.
  - RUN -> TIMEOUT when timeout_i != 0 and cycles_o == timeout_i - 1, with no terminate event in the same cycle.
  - DONE and TIMEOUT are absorbing until reset. If terminate and timeout coincide, terminate wins.
- Counter: increments each cycle in RUN; saturates at all-ones.
- Per-port capture (RUN only; tohost_addr_i != 0):
  - Condition: mem_addr == tohost_addr_i && mem_wmask != 0 && mem_wdata != 0. The valid bit is not required.
  - On capture: pending <= 1, pdata <= mem_wdata.
  - A later capture overwrites the earlier one.
- RV32 only: any write satisfying the same conditions with mem_addr == tohost_addr_i + 4 sets upper_q <= mem_wdata. upper_q is shared across ports and is not cleared on consumption.
- Store decode, is_store_wd, asserted for either:
  - uncompressed: opcode 0100011 with funct3 010, or funct3 011 when XLEN == 64;
  - compressed: insn[1:0] == 00 with insn[15:13] == 110, or insn[15:13] == 111 when XLEN == 64.
- Terminate event on port i: valid && is_store_wd && (pending_i || capture condition true this cycle) && data bit0 == 1.
  - Data is the current-cycle mem_wdata when the capture condition is true this cycle (bypass), otherwise pdata_i.
  - Consumption clears pending_i whether or not bit0 is 1.
- Trap: trap && !valid on port i clears pending_i.
- Multiple ports terminating in one cycle: the lowest index wins.
- Output latency: done_o, pass_o, exit_code_o, done_pc_o and done_port_o update on the clock edge that samples the event (1-cycle registered latency) and are frozen afterwards.
- RV64: exit_code_o = data. RV32: exit_code_o = {upper_q, data[31:0]}.
- pass_o = (exit_code_o == 64'h1).
- enable_i = 0 in DONE or TIMEOUT has no effect.
- Asynchronous reset mid-operation returns everything to the reset values regardless of state.

Decomposition:
- Package rvfi_monitor_pkg:
  - mon_state_e enum (IDLE, RUN, DONE, TIMEOUT);
  - function is_store_wd(insn, xlen);
  - localparam TOHOST_UPPER_OFFSET = 4.
- Sub-module rvfi_tohost_port: per-port capture register, bypass, trap clear and terminate flag with data. It is instantiated NR_COMMIT_PORTS times; the top level does priority selection, the FSM and the counter.

Test Plan:
1. RV64, tohost 0x8000_1000; port0: SD wdata 0x1 with valid and capture in the same cycle -> done_o = 1 and pass_o = 1 next cycle, exit_code_o = 0x1, done_port_o = 0.
2. RV64; port1 captures 0x7 with valid = 0 at cycle N, then C.SD valid on port1 at N+3 -> done_o at N+4, exit_code_o = 0x7, pass_o = 0.
3. Both ports terminate in one cycle (port0 0x1, port1 0x3) -> done_port_o = 0, exit_code_o = 0x1.
4. Capture on port0, then trap with valid = 0 on port0, then SW valid without a new capture -> no done; timeout_i = 50 -> timeout_o = 1 after 50 RUN cycles, cycles_o = 50.
5. RV32: SW 0xDEAD to tohost+4, then SW 0x1 to tohost -> exit_code_o = 0x0000_DEAD_0000_0001, pass_o = 0.
6. Assert reset while in DONE; toggle enable_i low for 10 cycles in RUN -> all outputs return to 0; cycles_o holds while enable_i is low; tohost_addr_i = 0 never yields done.
